// File: rtl/sramlike_bus_arbiter.sv
// sramlike_bus_arbiter: shares one sram-like memory port between the inst and data masters.
// One transaction may be outstanding at a time; ties go round-robin (FAIR=1) or to data (FAIR=0).
module sramlike_bus_arbiter #(
    parameter logic FAIR = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_inst_req,
    input  logic        i_inst_wr,
    input  logic [1:0]  i_inst_size,
    input  logic [31:0] i_inst_addr,
    input  logic [31:0] i_inst_wdata,
    output logic [31:0] o_inst_rdata,
    output logic        o_inst_addr_ok,
    output logic        o_inst_data_ok,
    input  logic        i_data_req,
    input  logic        i_data_wr,
    input  logic [1:0]  i_data_size,
    input  logic [31:0] i_data_addr,
    input  logic [31:0] i_data_wdata,
    output logic [31:0] o_data_rdata,
    output logic        o_data_addr_ok,
    output logic        o_data_data_ok,
    output logic        o_mem_req,
    output logic        o_mem_wr,
    output logic [1:0]  o_mem_size,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_addr_ok,
    input  logic        i_mem_data_ok
);
    typedef enum logic [1:0] {IDLE, I_WAIT, D_WAIT} state_t;

    state_t r_state;
    state_t w_next;
    logic   r_last_data;
    logic   w_idle;
    logic   w_sel_data;
    logic   w_acc;

    // The data master drives the mux whenever inst is not the winner, including during reset.
    assign w_sel_data = ~i_rst_n | ~i_inst_req | (i_data_req & (~FAIR | ~r_last_data));
    assign w_idle     = i_rst_n & (r_state == IDLE);

    assign o_mem_req   = w_idle & (i_inst_req | i_data_req);
    assign o_mem_wr    = w_sel_data ? i_data_wr    : i_inst_wr;
    assign o_mem_size  = w_sel_data ? i_data_size  : i_inst_size;
    assign o_mem_addr  = w_sel_data ? i_data_addr  : i_inst_addr;
    assign o_mem_wdata = w_sel_data ? i_data_wdata : i_inst_wdata;

    assign o_inst_addr_ok = w_idle & ~w_sel_data & i_mem_addr_ok;
    assign o_data_addr_ok = w_idle & w_sel_data & i_data_req & i_mem_addr_ok;
    assign w_acc          = o_inst_addr_ok | o_data_addr_ok;

    assign o_inst_data_ok = i_rst_n & i_mem_data_ok & ((r_state == I_WAIT) | o_inst_addr_ok);
    assign o_data_data_ok = i_rst_n & i_mem_data_ok & ((r_state == D_WAIT) | o_data_addr_ok);
    assign o_inst_rdata   = i_mem_rdata;
    assign o_data_rdata   = i_mem_rdata;

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE) begin
            if (w_acc && !i_mem_data_ok)
                w_next = w_sel_data ? D_WAIT : I_WAIT;
        end else if (i_mem_data_ok) begin
            w_next = IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_last_data <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_acc)
                r_last_data <= w_sel_data;
        end
    end
endmodule
